sig_sync_filt: RTL and testbench

- Multi-channel input conditioner for the Kanalog buffer's opto/field digital inputs.
- Each channel passes through an N-stage metastability synchronizer.
- A runtime-programmable glitch/debounce filter follows the synchronizer.
- Registered rise/fall pulses are produced per channel, with an aggregate change flag for the host-side register/interrupt logic.

---
 rtl/sig_sync_filt.sv | 94 +++++++++
 tb/tb_sig_sync_filt.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sig_sync_filt.sv
// sig_sync_filt
//   Multi-channel input conditioner: per-channel metastability synchronizer,
//   followed by a runtime-programmable debounce filter and registered
//   rise/fall edge pulses.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   async_in   - WIDTH raw asynchronous inputs
//   filt_len   - required stable-cycle count (0 and 1 both mean one cycle)
//   sync_out   - synchronized, filtered level per channel
//   rise       - 1-cycle pulse in the first cycle sync_out shows 0->1
//   fall       - 1-cycle pulse in the first cycle sync_out shows 1->0
//   any_change - registered OR of all rise|fall bits, coincident with them
module sig_sync_filt #(
  parameter int              WIDTH       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_BITS   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     async_in,
  input  logic [FILT_BITS-1:0] filt_len,
  output logic [WIDTH-1:0]     sync_out,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 any_change
);

  // Fewer than two stages gives no real MTBF protection, so clamp.
  localparam int NSTG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [FILT_BITS-1:0] ONE = FILT_BITS'(1);

  logic [WIDTH-1:0]     s;          // synchronizer output per channel
  logic [WIDTH-1:0]     f;          // filtered level
  logic [WIDTH-1:0]     f_next;
  logic [WIDTH-1:0]     rise_next;
  logic [WIDTH-1:0]     fall_next;
  logic [FILT_BITS-1:0] cnt    [WIDTH];
  logic [FILT_BITS-1:0] c_next [WIDTH];
  logic [FILT_BITS-1:0] lim;        // Neff-1

  // filt_len of 0 behaves like 1: commit on the first counted disagreement.
  assign lim = (filt_len == '0) ? '0 : (filt_len - ONE);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      // Pure register chain, nothing between stages.
      logic [NSTG-1:0] chain;
      logic            diff;
      logic            commit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= {NSTG{RESET_VAL[gi]}};
        end else begin
          chain <= {chain[NSTG-2:0], async_in[gi]};
        end
      end

      assign s[gi] = chain[NSTG-1];

      // ">=" rather than "==" so a shortened filt_len mid-count commits
      // on the next disagreeing cycle instead of counting round a wrap.
      // The counter only increments while below lim, so it cannot overflow.
      assign diff          = s[gi] ^ f[gi];
      assign commit        = diff && (cnt[gi] >= lim);
      assign f_next[gi]    = commit ? s[gi] : f[gi];
      assign c_next[gi]    = (!diff || commit) ? '0 : (cnt[gi] + ONE);
      assign rise_next[gi] = commit &  s[gi];
      assign fall_next[gi] = commit & ~s[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f          <= RESET_VAL;
      cnt        <= '{default: '0};
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      f          <= f_next;
      cnt        <= c_next;
      rise       <= rise_next;
      fall       <= fall_next;
      any_change <= |(rise_next | fall_next);
    end
  end

  assign sync_out = f;

endmodule

// File: tb/tb_sig_sync_filt.sv
// tb_sig_sync_filt
//   Directed bench for sig_sync_filt (WIDTH=8, SYNC_STAGES=2, FILT_BITS=4,
//   RESET_VAL=0). Inputs change 1 time unit after a rising edge; outputs are
//   sampled at the same point, i.e. after "edge k" as counted from the first
//   rising edge following the stimulus change.
module tb_sig_sync_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] async_in;
  logic [3:0] filt_len;
  logic [7:0] sync_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       any_change;

  int total = 0;
  int bad   = 0;

  sig_sync_filt #(
    .WIDTH(8), .SYNC_STAGES(2), .FILT_BITS(4), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len),
    .sync_out(sync_out), .rise(rise), .fall(fall), .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_sync,
                           input logic [7:0] e_rise, input logic [7:0] e_fall);
    check({tag, "_sync"}, 32'(sync_out), 32'(e_sync));
    check({tag, "_rise"}, 32'(rise), 32'(e_rise));
    check({tag, "_fall"}, 32'(fall), 32'(e_fall));
    check({tag, "_any"}, 32'(any_change), 32'(((e_rise | e_fall) != 8'h00) ? 1 : 0));
  endtask

  // Square wave for the bypass test: 3 high, 3 low, for t in 0..17.
  function automatic logic sq(input int t);
    return (t >= 0) && (t < 18) && (((t / 3) % 2) == 0);
  endfunction

  logic [23:0] trace0, trace1;

  initial begin
    // ---------------- reset ----------------
    rst_n    = 1'b0;
    async_in = 8'hFF;
    filt_len = 4'd3;
    #2;
    check_all("rst_async", 8'h00, 8'h00, 8'h00);
    tick(); tick(); tick();
    check_all("rst_hold", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    $display("release reset, filt_len=3, async_in=FF");
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_all($sformatf("rel_e%0d", k), (k >= 5) ? 8'hFF : 8'h00,
                (k == 5) ? 8'hFF : 8'h00, 8'h00);
    end

    // Bring everything low with filt_len=4 (fall after 2+4 edges).
    filt_len = 4'd4;
    async_in = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("down_e%0d", k), (k >= 6) ? 8'h00 : 8'hFF,
                8'h00, (k == 6) ? 8'hFF : 8'h00);
    end

    // ---------------- glitch: 3-clock pulse rejected ----------------
    $display("glitch: ch0 high 3 clocks, filt_len=4");
    for (int k = 1; k <= 10; k++) begin
      async_in = (k <= 3) ? 8'h01 : 8'h00;
      tick();
      check_all($sformatf("gl3_e%0d", k), 8'h00, 8'h00, 8'h00);
    end

    // ---------------- 4-clock pulse accepted ----------------
    $display("pulse: ch0 high 4 clocks, filt_len=4");
    for (int k = 1; k <= 12; k++) begin
      async_in = (k <= 4) ? 8'h01 : 8'h00;
      tick();
      check_all($sformatf("gl4_e%0d", k), (k >= 6 && k <= 9) ? 8'h01 : 8'h00,
                (k == 6) ? 8'h01 : 8'h00, (k == 10) ? 8'h01 : 8'h00);
    end

    // ---------------- bypass: filt_len 0 and 1 ----------------
    for (int run = 0; run < 2; run++) begin
      filt_len = 4'(run);
      $display("bypass: ch3 square wave, filt_len=%0d", run);
      for (int k = 1; k <= 24; k++) begin
        async_in = {4'h0, sq(k - 1), 3'b000};
        tick();
        check_all($sformatf("byp%0d_e%0d", run, k), {4'h0, sq(k - 3), 3'b000},
                  {4'h0, sq(k - 3) & ~sq(k - 4), 3'b000},
                  {4'h0, ~sq(k - 3) & sq(k - 4), 3'b000});
        if (run == 0) trace0[k-1] = sync_out[3];
        else          trace1[k-1] = sync_out[3];
      end
    end
    check("byp_trace_same", 32'(trace1), 32'(trace0));

    // ---------------- dynamic length ----------------
    $display("dynamic: filt_len=15, ch5 high, shorten to 2 after edge 8");
    filt_len = 4'd15;
    async_in = 8'h20;
    for (int k = 1; k <= 10; k++) begin
      if (k == 9) filt_len = 4'd2;
      tick();
      check_all($sformatf("dyn_e%0d", k), (k >= 9) ? 8'h20 : 8'h00,
                (k == 9) ? 8'h20 : 8'h00, 8'h00);
    end

    // ---------------- chatter on ch1, single step on ch2 ----------------
    $display("chatter: ch1 toggles 100 clocks, ch2 steps after edge 10");
    filt_len = 4'd2;
    for (int k = 1; k <= 100; k++) begin
      async_in = 8'h20 | ((k > 10) ? 8'h04 : 8'h00) | ((k % 2) != 0 ? 8'h02 : 8'h00);
      tick();
      check_all($sformatf("chat_e%0d", k), 8'h20 | ((k >= 14) ? 8'h04 : 8'h00),
                (k == 14) ? 8'h04 : 8'h00, 8'h00);
    end

    // ---------------- async reset mid-count ----------------
    $display("async reset mid-count: ch6 high, filt_len=4");
    filt_len = 4'd4;
    async_in = 8'h64;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_all($sformatf("arst_pre_e%0d", k), 8'h24, 8'h00, 8'h00);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_all("arst_immediate", 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check_all("arst_held", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all($sformatf("arst_post_e%0d", k), (k >= 6) ? 8'h64 : 8'h00,
                (k == 6) ? 8'h64 : 8'h00, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
